// File: rtl/apb_master_fsm.sv
// APB requester: turns single-word valid/ready commands into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse, with a wait-state timeout on every transfer.
module apb_master_fsm #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                pwrite_q, pwrite_d;
  logic [AWIDTH-1:0]   paddr_q, paddr_d;
  logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready   = (state_q == StIdle) && !PRESET;
  assign PSEL        = (state_q != StIdle);
  assign PENABLE     = (state_q == StAccess);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    // Response fields are zero except in the single cycle after completion.
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = StSetup;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = 8'd0;
      end
      StAccess: begin
        // Completion wins over abort when PREADY arrives on the last allowed cycle.
        if (PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          if (!pwrite_q && !PSLVERR) begin
            rsp_rdata_d = PRDATA;
          end
        end else if (cnt_q == TimeoutCnt) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: directed and randomized transfers checked cycle by cycle against
// expectations derived from transfer length, wait-state count and timeout limit.
module tb_apb_master_fsm;

  localparam int T = 4;

  logic       PCLK, PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_master_fsm #(
    .AWIDTH (4),
    .DWIDTH (8),
    .TIMEOUT(T)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic garbage_apb();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = 8'($urandom);
  endtask

  task automatic garbage_cmd(input logic valid);
    cmd_valid = valid;
    cmd_write = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  // One command with `waits` PREADY-low ACCESS cycles before PREADY rises; waits > T never
  // raises PREADY inside the allowed window, so the transfer must time out.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d, input int waits,
                      input logic e, input logic [7:0] rd, input logic hold);
    logic to;
    int   acc_len;
    to      = (waits > T);
    acc_len = to ? T + 1 : waits + 1;

    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    garbage_apb();
    @(negedge PCLK);
    chk("accept_ready", cmd_ready, 1);
    chk("idle_psel", PSEL, 0);

    for (int i = 0; i <= acc_len; i++) begin
      @(posedge PCLK); #1;
      garbage_cmd(hold ? 1'b1 : 1'($urandom));
      if (i == 0) begin
        garbage_apb();
      end else if (i - 1 < waits) begin
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end else begin
        PREADY  = 1'b1;
        PSLVERR = e;
        PRDATA  = rd;
      end
      @(negedge PCLK);
      chk("busy_psel", PSEL, 1);
      chk("busy_penable", PENABLE, (i != 0));
      chk("busy_ready", cmd_ready, 0);
      chk("busy_rsp_valid", rsp_valid, 0);
      chk("busy_paddr", PADDR, a);
      chk("busy_pwrite", PWRITE, w);
      chk("busy_pwdata", PWDATA, d);
    end

    @(posedge PCLK); #1;
    garbage_cmd(1'b0);
    garbage_apb();
    @(negedge PCLK);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, (to || e));
    chk("rsp_timeout", rsp_timeout, to);
    chk("rsp_rdata", rsp_rdata, (!to && !w && !e) ? rd : 8'h00);
    chk("rsp_psel", PSEL, 0);
    chk("rsp_penable", PENABLE, 0);
    chk("rsp_ready", cmd_ready, 1);
    chk("rsp_paddr_hold", PADDR, a);
    chk("rsp_pwrite_hold", PWRITE, w);

    @(posedge PCLK); #1;
    garbage_apb();
    @(negedge PCLK);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("after_ready", cmd_ready, 1);
    chk("after_psel", PSEL, 0);
  endtask

  initial begin
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

    // Reset held 3 cycles with a command offered; nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      garbage_cmd(1'b1);
      garbage_apb();
      @(negedge PCLK);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
      chk("rst_bus", {PWRITE, PADDR, PWDATA}, 0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_release_ready", cmd_ready, 1);
    chk("rst_release_psel", PSEL, 0);

    // Directed transfers.
    xfer(1'b1, 4'h2, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
    xfer(1'b0, 4'h6, 8'h11, 2, 1'b0, 8'h3C, 1'b1);
    xfer(1'b0, 4'h7, 8'h22, 1, 1'b1, 8'h5A, 1'b0);
    xfer(1'b0, 4'h8, 8'h33, 100, 1'b0, 8'h77, 1'b1);
    xfer(1'b0, 4'h9, 8'h44, T, 1'b0, 8'hC3, 1'b0);
    xfer(1'b1, 4'hA, 8'h55, T, 1'b1, 8'h99, 1'b0);

    // Reset during a wait state, with PREADY high in the reset cycle.
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hB; cmd_wdata = 8'h66;
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_accept", cmd_ready, 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_setup_pen", PENABLE, 0);
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_access_pen", PENABLE, 1);
    @(posedge PCLK); #1;
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 8'hEE; PSLVERR = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_ready", cmd_ready, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_paddr", PADDR, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      garbage_apb();
      @(negedge PCLK);
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_idle_psel", PSEL, 0);
    end
    xfer(1'b0, 4'hC, 8'h00, 1, 1'b0, 8'h81, 1'b0);

    // Randomized transfers; waits above T exercise the timeout path.
    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, T + 2)),
           1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
